// File: rtl/timestamp_sampler.sv
// Avalon-MM master for the interval timer: programs it for free-running
// down-counting, then turns snapshot reads into elapsed-tick and delta values.
module timestamp_sampler #(
   parameter logic [31:0] PERIOD    = 32'hFFFF_FFFF,
   parameter logic [15:0] CTRL_INIT = 16'h0006
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic        sample_req,
   output logic        busy,
   output logic        ts_valid,
   output logic [31:0] ts_value,
   output logic [31:0] ts_delta,
   output logic        overflow,
   input  logic        clr_overflow,
   output logic [2:0]  tt_address,
   output logic [15:0] tt_writedata,
   input  logic [15:0] tt_readdata,
   output logic        tt_chipselect,
   output logic        tt_write_n
);

   typedef enum logic [2:0] {
      S_INIT_PL,
      S_INIT_PH,
      S_INIT_CTRL,
      S_IDLE,
      S_SNAP_WR,
      S_RD_LO,
      S_RD_HI,
      S_RD_END
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic        pending;
   logic [15:0] snap_lo;
   logic [31:0] prev_value;
   logic [31:0] elapsed;
   logic        drop;

   // Bus handshake: a write is a single cycle with chipselect=1, write_n=0;
   // a read presents the address with chipselect=1, write_n=1 and the data
   // returns on tt_readdata in the next cycle (no waitrequest).
   always_comb begin
      state_nx      = state;
      busy          = 1'b1;
      tt_chipselect = 1'b0;
      tt_write_n    = 1'b1;
      tt_address    = 3'd0;
      tt_writedata  = 16'd0;
      case (state)
         S_INIT_PL: begin
            tt_chipselect = 1'b1;
            tt_write_n    = 1'b0;
            tt_address    = 3'd2;
            tt_writedata  = PERIOD[15:0];
            state_nx      = S_INIT_PH;
         end
         S_INIT_PH: begin
            tt_chipselect = 1'b1;
            tt_write_n    = 1'b0;
            tt_address    = 3'd3;
            tt_writedata  = PERIOD[31:16];
            state_nx      = S_INIT_CTRL;
         end
         S_INIT_CTRL: begin
            tt_chipselect = 1'b1;
            tt_write_n    = 1'b0;
            tt_address    = 3'd1;
            tt_writedata  = CTRL_INIT;
            state_nx      = S_IDLE;
         end
         S_IDLE: begin
            busy = 1'b0;
            if (sample_req || pending) state_nx = S_SNAP_WR;
         end
         S_SNAP_WR: begin
            tt_chipselect = 1'b1;
            tt_write_n    = 1'b0;
            tt_address    = 3'd4;
            state_nx      = S_RD_LO;
         end
         S_RD_LO: begin
            tt_chipselect = 1'b1;
            tt_address    = 3'd4;
            state_nx      = S_RD_HI;
         end
         S_RD_HI: begin
            tt_chipselect = 1'b1;
            tt_address    = 3'd5;
            state_nx      = S_RD_END;
         end
         S_RD_END: state_nx = S_IDLE;
         default:  state_nx = S_INIT_PL;
      endcase
      // Keep the bus quiet while reset is held so the init writes start cleanly on release.
      if (!reset_reset_n) begin
         busy          = 1'b1;
         tt_chipselect = 1'b0;
         tt_write_n    = 1'b1;
         tt_address    = 3'd0;
         tt_writedata  = 16'd0;
      end
   end

   assign elapsed = PERIOD - {tt_readdata, snap_lo};
   assign drop    = sample_req && pending && (state != S_IDLE);

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state      <= S_INIT_PL;
         pending    <= 1'b0;
         overflow   <= 1'b0;
         snap_lo    <= 16'd0;
         prev_value <= 32'd0;
         ts_value   <= 32'd0;
         ts_delta   <= 32'd0;
         ts_valid   <= 1'b0;
      end else begin
         state    <= state_nx;
         ts_valid <= (state == S_RD_END);
         if (state == S_RD_HI) snap_lo <= tt_readdata;
         if (state == S_RD_END) begin
            ts_value   <= elapsed;
            ts_delta   <= elapsed - prev_value;
            prev_value <= elapsed;
         end
         // In IDLE the pending slot is consumed; a simultaneous request refills it.
         if (state == S_IDLE) pending <= pending && sample_req;
         else if (sample_req && !pending) pending <= 1'b1;
         if (drop) overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_timestamp_sampler.sv
// Bench for timestamp_sampler: a timer slave model feeds snapshots, a
// scoreboard checks results, and directed plus random phases exercise it.
module tb_timestamp_sampler;

  localparam logic [31:0] PERIOD = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_req = 1'b0;
  logic        clr_overflow = 1'b0;
  logic        busy;
  logic        ts_valid;
  logic [31:0] ts_value;
  logic [31:0] ts_delta;
  logic        overflow;
  logic [2:0]  tt_address;
  logic [15:0] tt_writedata;
  logic [15:0] tt_readdata = 16'd0;
  logic        tt_chipselect;
  logic        tt_write_n;

  int total = 0;
  int bad = 0;
  int valid_count = 0;

  logic [63:0] exp_q[$];
  logic [31:0] snap_plan[$];
  logic [31:0] prev_model = 32'd0;
  logic [31:0] timer_snap = 32'd0;

  timestamp_sampler #(.PERIOD(PERIOD), .CTRL_INIT(16'h0006)) dut (
    .clk_clk       (clk),
    .reset_reset_n (reset_n),
    .sample_req    (sample_req),
    .busy          (busy),
    .ts_valid      (ts_valid),
    .ts_value      (ts_value),
    .ts_delta      (ts_delta),
    .overflow      (overflow),
    .clr_overflow  (clr_overflow),
    .tt_address    (tt_address),
    .tt_writedata  (tt_writedata),
    .tt_readdata   (tt_readdata),
    .tt_chipselect (tt_chipselect),
    .tt_write_n    (tt_write_n)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bus_word(input logic cs, input logic wn,
                                           input logic [2:0] a, input logic [15:0] d);
    return {11'd0, cs, wn, a, d};
  endfunction

  function automatic logic [31:0] bus_now();
    return {11'd0, tt_chipselect, tt_write_n, tt_address, tt_writedata};
  endfunction

  // timer slave model: latches a snapshot on a snapl write, answers reads one cycle later
  always begin
    logic [2:0] rd_addr;
    logic       rd_en;
    logic [31:0] val;
    @(negedge clk);
    rd_en = reset_n && tt_chipselect && tt_write_n;
    rd_addr = tt_address;
    if (reset_n && tt_chipselect && !tt_write_n && tt_address == 3'd4) begin
      timer_snap = (snap_plan.size() != 0) ? snap_plan.pop_front() : $urandom;
      val = PERIOD - timer_snap;
      exp_q.push_back({val, val - prev_model});
      prev_model = val;
    end
    @(posedge clk);
    #1;
    if (rd_en && rd_addr == 3'd4) tt_readdata = timer_snap[15:0];
    else if (rd_en && rd_addr == 3'd5) tt_readdata = timer_snap[31:16];
    else tt_readdata = 16'd0;
  end

  // scoreboard
  always @(negedge clk) begin
    logic [63:0] e;
    if (reset_n && ts_valid) begin
      valid_count++;
      if (exp_q.size() == 0) check("sb_extra_valid", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("sb_value", ts_value, e[63:32]);
        check("sb_delta", ts_delta, e[31:0]);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_bus"}, bus_now(), bus_word(0, 1, 0, 0));
    check({tag, "_valid"}, ts_valid, 0);
    check({tag, "_value"}, ts_value, 0);
    check({tag, "_delta"}, ts_delta, 0);
    check({tag, "_ovf"}, overflow, 0);
  endtask

  // call right after reset release (#1 after the edge)
  task automatic check_init(input string tag);
    @(negedge clk); check({tag, "_pl"}, bus_now(), bus_word(1, 0, 2, 16'hFFFF));
    check({tag, "_busy_pl"}, busy, 1);
    @(negedge clk); check({tag, "_ph"}, bus_now(), bus_word(1, 0, 3, 16'hFFFF));
    @(negedge clk); check({tag, "_ctrl"}, bus_now(), bus_word(1, 0, 1, 16'h0006));
    @(negedge clk); check({tag, "_idle_bus"}, bus_now(), bus_word(0, 1, 0, 0));
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  task automatic run_sample(input string tag, input logic [31:0] snap,
                            input logic [31:0] want_val, input logic [31:0] want_delta);
    snap_plan.push_back(snap);
    @(posedge clk); #1 sample_req = 1'b1;
    @(negedge clk); check({tag, "_idle"}, busy, 0);
    @(posedge clk); #1 sample_req = 1'b0;
    @(negedge clk); check({tag, "_snap_wr"}, bus_now(), bus_word(1, 0, 4, 0));
    @(negedge clk); check({tag, "_rd_lo"}, bus_now(), bus_word(1, 1, 4, 0));
    @(negedge clk); check({tag, "_rd_hi"}, bus_now(), bus_word(1, 1, 5, 0));
    @(negedge clk); check({tag, "_rd_end"}, {busy, tt_chipselect, ts_valid}, 3'b100);
    @(negedge clk); check({tag, "_valid"}, ts_valid, 1);
    check({tag, "_value"}, ts_value, want_val);
    check({tag, "_delta"}, ts_delta, want_delta);
    @(negedge clk); check({tag, "_valid_drop"}, ts_valid, 0);
    check({tag, "_hold"}, ts_value, want_val);
  endtask

  initial begin
    int base;
    int outstanding;
    int accepted;
    logic exp_ovf;
    logic dropped;

    // reset and init sequence
    repeat (3) @(posedge clk);
    @(negedge clk); check_reset_outputs("rst");
    @(posedge clk); #1 reset_n = 1'b1;
    check_init("init");

    // directed samples
    run_sample("s1", 32'hFFFF_FFF0, 32'h0000_000F, 32'h0000_000F);
    run_sample("s2", 32'hFFFF_FF00, 32'h0000_00FF, 32'h0000_00F0);

    // requests while busy: one queued, one dropped
    base = valid_count;
    @(posedge clk); #1 sample_req = 1'b1;
    @(posedge clk); #1 sample_req = 1'b1;
    @(posedge clk); #1 sample_req = 1'b0;
    @(posedge clk); #1 sample_req = 1'b1;
    @(posedge clk); #1 sample_req = 1'b0;
    @(negedge clk); check("ovf_set", overflow, 1);
    repeat (14) @(negedge clk);
    check("ovf_two_valids", valid_count - base, 2);
    check("ovf_sticky", overflow, 1);
    @(posedge clk); #1 clr_overflow = 1'b1;
    @(posedge clk); #1 clr_overflow = 1'b0;
    @(negedge clk); check("ovf_clear", overflow, 0);

    // reset in the middle of a read
    base = valid_count;
    snap_plan.push_back(32'h1234_5678);
    @(posedge clk); #1 sample_req = 1'b1;
    @(posedge clk); #1 sample_req = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    snap_plan.delete();
    prev_model = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk); check_reset_outputs("midrst");
    check("midrst_no_valid", valid_count - base, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    check_init("reinit");
    run_sample("s3", 32'hFFFF_FF00, 32'h0000_00FF, 32'h0000_00FF);

    // wrap-around of the elapsed count
    run_sample("w1", 32'h0000_000F, 32'hFFFF_FFF0, 32'hFFFF_FEF1);
    run_sample("w2", 32'hFFFF_FFEF, 32'h0000_0010, 32'h0000_0020);

    // random requests against a queue-occupancy model
    base = valid_count;
    outstanding = 0;
    accepted = 0;
    exp_ovf = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      sample_req = ($urandom_range(0, 3) == 0);
      clr_overflow = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      check("rnd_ovf", overflow, exp_ovf);
      if (ts_valid) outstanding--;
      dropped = 1'b0;
      if (sample_req) begin
        if (outstanding >= 2) dropped = 1'b1;
        else begin
          outstanding++;
          accepted++;
        end
      end
      if (dropped) exp_ovf = 1'b1;
      else if (clr_overflow) exp_ovf = 1'b0;
    end
    @(posedge clk); #1;
    sample_req = 1'b0;
    clr_overflow = 1'b0;
    repeat (15) @(negedge clk);
    check("rnd_valid_count", valid_count - base, accepted);
    check("rnd_queue_empty", exp_q.size(), 0);
    check("rnd_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timestamp_sampler.md
Name: timestamp_sampler

Overview:
- Avalon-MM master that sits directly upstream of the timestamp_timer slave port and drives it.
- On reset release it programs the interval timer for free-running 32-bit down-counting.
- On each sample request it latches the timer snapshot, reads it back, and converts it to an elapsed-tick count.
- It also produces the delta from the previous sample for software and other datapath consumers.

Parameters:
- PERIOD, 32'hFFFF_FFFF, value written to periodh:periodl at init; counter reload value.
- CTRL_INIT, 16'h0006, control register init value (CONT=1, START=1, ITO=0).

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  synchronous active-low reset
- sample_req  in  1  single-cycle pulse requesting a timestamp
- busy  out  1  high while the init or sample sequence is running
- ts_valid  out  1  one-cycle pulse; ts_value/ts_delta valid
- ts_value  out  32  elapsed ticks = PERIOD - snapshot
- ts_delta  out  32  ts_value - previous ts_value, mod 2^32
- overflow  out  1  sticky; a request was dropped
- clr_overflow  in  1  clears overflow
- tt_address  out  3  timer register address
- tt_writedata  out  16  timer write data
- tt_readdata  in  16  timer read data
- tt_chipselect  out  1  timer select
- tt_write_n  out  1  timer write strobe, active low

Behaviour:
- Timer register map: 0 status, 1 control, 2 periodl, 3 periodh, 4 snapl, 5 snaph. A write to snapl latches the counter.
- Bus timing:
  - Write: one cycle with chipselect=1, write_n=0, and address/writedata valid.
  - Read: address presented with chipselect=1, write_n=1; tt_readdata is sampled on the following cycle (fixed 1-cycle read latency, no waitrequest).
- Reset (reset_reset_n=0 at a clk edge):
  - All outputs 0, except busy=1 and tt_write_n=1.
  - prev_value=0, pending=0, state=INIT_PL.
  - Any sequence in flight is abandoned; no ts_valid is produced for it.
- FSM states and actions:
  - INIT_PL: write addr 2, data PERIOD[15:0].
  - INIT_PH: write addr 3, data PERIOD[31:16].
  - INIT_CTRL: write addr 1, data CTRL_INIT.
  - IDLE: busy=0, cs=0. On sample_req or pending -> SNAP_WR, clearing pending.
  - SNAP_WR: write addr 4, data 0.
  - RD_LO: read addr 4.
  - RD_HI: read addr 5; capture tt_readdata into snap[15:0].
  - RD_END: cs=0; capture tt_readdata into snap[31:16]; compute results -> IDLE.
- Init sequence: INIT_PL -> INIT_PH -> INIT_CTRL -> IDLE, one cycle each. Requests arriving during init set pending.
- Result registers, updated at the RD_END edge:
  - ts_value = PERIOD - snap (32-bit).
  - ts_delta = (PERIOD - snap) - prev_value, mod 2^32.
  - prev_value is updated to the new ts_value.
  - ts_valid=1 for exactly the following cycle.
- Latency: sample_req high in IDLE at cycle N -> SNAP_WR N+1, RD_LO N+2, RD_HI N+3, RD_END N+4, ts_valid high in cycle N+5.
  - ts_value/ts_delta hold their value until the next update.
- busy is 1 in every state except IDLE.
- Request handling while busy:
  - The first request sets pending (single-entry queue).
  - A request while pending=1 is dropped and sets overflow.
  - A request in the same cycle as a pending-consume in IDLE sets pending again.
- clr_overflow clears overflow. If a drop occurs in the same cycle, the set wins.
- Wrap-around: the timer reloads at 0, so ts_value is modulo PERIOD+1. ts_delta is exact across one wrap only when PERIOD=32'hFFFF_FFFF.
- tt_address and tt_writedata are 0 whenever cs=0.

Test Plan:
- Reset release -> writes (addr 2, 0xFFFF), (3, 0xFFFF), (1, 0x0006) on 3 consecutive cycles; busy falls on the 4th cycle; tt_write_n=1 otherwise.
- Idle, pulse sample_req with a model returning snapl=0xFFF0, snaph=0xFFFF -> write addr 4 at N+1, reads 4/5 at N+2/N+3; ts_valid at N+5 with ts_value=0x0000_000F and ts_delta=0x0000_000F.
- Second sample with snap=0xFFFF_FF00 -> ts_value=0x0000_00FF, ts_delta=0x0000_00F0.
- sample_req during SNAP_WR, then again during RD_HI -> one extra sequence runs straight after IDLE; overflow=1; exactly 2 ts_valid pulses total. clr_overflow -> overflow=0.
- Reset asserted in RD_HI -> no ts_valid, outputs zeroed, init write sequence restarts, prev_value=0.
- Wrap: prev ts_value=0xFFFF_FFF0, next snap=0xFFFF_FFEF -> ts_value=0x10, ts_delta=0x20.
